// File: rtl/tile_push_arbiter.sv
// Round-robin burst arbiter sharing one tile FIFO push port among NREQ producers.
// A grant is held until a last-marked tile or MAX_BURST accepted tiles, then released.
module tile_push_arbiter #(
  parameter int BITS      = 8,
  parameter int SIZE      = 2,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NREQ-1:0]                               req_valid,
  input  logic [NREQ-1:0]                               req_last,
  input  logic [NREQ-1:0][SIZE-1:0][SIZE-1:0][BITS-1:0] req_data,
  output logic [NREQ-1:0]                               req_ready,
  output logic                                          fifo_push,
  input  logic                                          fifo_push_rdy,
  output logic [SIZE-1:0][SIZE-1:0][BITS-1:0]           fifo_din,
  output logic [NREQ-1:0]                               grant,
  output logic                                          preempt,
  output logic [15:0]                                   tile_count
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_r;
  logic [NREQ-1:0] grant_r;
  logic [PW-1:0]   gidx_r;
  logic [PW-1:0]   rr_ptr_r;
  logic [BW-1:0]   beat_cnt_r;
  logic            preempt_r;
  logic [15:0]     tile_count_r;

  logic                                 found_s;
  logic [PW-1:0]                        pick_s;
  logic [NREQ-1:0]                      req_ready_s;
  logic                                 accept_s;
  logic                                 last_s;
  logic [SIZE-1:0][SIZE-1:0][BITS-1:0]  fifo_din_s;
  logic                                 burst_end_s;
  logic [PW-1:0]                        rr_next_s;

  // Round-robin search: first valid index at or above rr_ptr, wrapping explicitly at NREQ.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      logic [PW:0] idx_v;
      logic        hit_v;
      idx_v   = {1'b0, rr_ptr_r} + (PW+1)'(k);
      idx_v   = (idx_v >= (PW+1)'(NREQ)) ? idx_v - (PW+1)'(NREQ) : idx_v;
      hit_v   = !found_s && req_valid[idx_v[PW-1:0]];
      pick_s  = hit_v ? idx_v[PW-1:0] : pick_s;
      found_s = found_s | hit_v;
    end
  end

  // Handshake and data mux, combinational from the registered grant index.
  always_comb begin
    req_ready_s = '0;
    fifo_din_s  = '0;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    if (state_r == GRANT) begin
      req_ready_s[gidx_r] = fifo_push_rdy;
      fifo_din_s          = req_data[gidx_r];
      accept_s            = req_valid[gidx_r] & fifo_push_rdy;
      last_s              = req_last[gidx_r];
    end else begin
      req_ready_s = '0;
      fifo_din_s  = '0;
      accept_s    = 1'b0;
      last_s      = 1'b0;
    end
  end

  assign burst_end_s = (beat_cnt_r == BW'(MAX_BURST - 1));
  assign rr_next_s   = (gidx_r == PW'(NREQ - 1)) ? '0 : gidx_r + PW'(1);

  // Arbitration state machine; preempt is a one-cycle pulse cleared on the following IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      gidx_r       <= '0;
      rr_ptr_r     <= '0;
      beat_cnt_r   <= '0;
      preempt_r    <= 1'b0;
      tile_count_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          preempt_r <= 1'b0;
          if (found_s) begin
            state_r    <= GRANT;
            grant_r    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
            gidx_r     <= pick_s;
            beat_cnt_r <= '0;
          end else begin
            state_r <= IDLE;
            grant_r <= '0;
          end
        end
        GRANT: begin
          preempt_r <= 1'b0;
          if (accept_s) begin
            tile_count_r <= tile_count_r + 16'd1;
            if (last_s || burst_end_s) begin
              state_r    <= IDLE;
              grant_r    <= '0;
              rr_ptr_r   <= rr_next_s;
              beat_cnt_r <= '0;
              preempt_r  <= !last_s;
            end else begin
              beat_cnt_r <= beat_cnt_r + BW'(1);
            end
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          grant_r    <= '0;
          beat_cnt_r <= '0;
          preempt_r  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign fifo_push  = accept_s;
  assign fifo_din   = fifo_din_s;
  assign grant      = grant_r;
  assign preempt    = preempt_r;
  assign tile_count = tile_count_r;

endmodule

// File: tb/tb_tile_push_arbiter.sv
// Bench for tile_push_arbiter: per-requester tile queues drive the DUT and a
// per-requester scoreboard checks every pushed tile, plus cycle-exact grant tables.
module tb_tile_push_arbiter;
  localparam int BITS = 8, SIZE = 2, NREQ = 4, MAX_BURST = 4;
  localparam int TW = SIZE * SIZE * BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [NREQ-1:0][SIZE-1:0][SIZE-1:0][BITS-1:0] req_data = '0;
  logic fifo_push, preempt;
  logic fifo_push_rdy = 1'b1;
  logic [SIZE-1:0][SIZE-1:0][BITS-1:0] fifo_din;
  logic [15:0] tile_count;

  logic [TW:0]   src_q[NREQ][$];
  logic [TW-1:0] exp_q[NREQ][$];
  int checks = 0, errors = 0, preempt_seen = 0;
  logic [NREQ-1:0] g_smp, rdy_smp;
  logic push_smp, pre_smp;
  logic [15:0] cnt_smp;

  tile_push_arbiter #(.BITS(BITS), .SIZE(SIZE), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_push(fifo_push),
    .fifo_push_rdy(fifo_push_rdy), .fifo_din(fifo_din), .grant(grant),
    .preempt(preempt), .tile_count(tile_count));

  task automatic refresh();
    logic [TW:0] h;
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        req_valid[i] = 1'b1;
        req_last[i]  = h[TW];
        req_data[i]  = h[TW-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i]  = '0;
      end
    end
  endtask

  task automatic add(input int i, input logic last);
    logic [TW-1:0] d;
    d = TW'($urandom());
    src_q[i].push_back({last, d});
    exp_q[i].push_back(d);
    refresh();
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (exp_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // One clock: sample mid-cycle, score any push, then advance the producer queues.
  task automatic step();
    logic [NREQ-1:0] acc;
    logic [TW-1:0] e;
    int gi;
    @(negedge clk);
    g_smp = grant; rdy_smp = req_ready; push_smp = fifo_push;
    pre_smp = preempt; cnt_smp = tile_count;
    acc = req_valid & req_ready;
    if (preempt) preempt_seen++;
    if (rst_n && fifo_push) begin
      checks++;
      if (fifo_push_rdy !== 1'b1) begin
        errors++; $display("FAIL push_while_full: fifo_push=1 with fifo_push_rdy=%b", fifo_push_rdy);
      end
      gi = -1;
      for (int i = 0; i < NREQ; i++) if (grant[i]) gi = i;
      checks++;
      if (gi < 0 || exp_q[gi].size() == 0) begin
        errors++; $display("FAIL unexpected_push: grant=%b din=%h, no tile expected", grant, fifo_din);
      end else begin
        e = exp_q[gi].pop_front();
        if (fifo_din !== e) begin
          errors++; $display("FAIL push_data req%0d: got %h expected %h", gi, fifo_din, e);
        end
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    refresh();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin src_q[i].delete(); exp_q[i].delete(); end
    fifo_push_rdy = 1'b1;
    refresh();
    #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    preempt_seen = 0;
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] exp, input int budget);
    int n;
    n = 0;
    do begin step(); n++; end while (g_smp == '0 && n < budget);
    checks++;
    if (g_smp !== exp) begin errors++; $display("FAIL wait_grant: got %b expected %b", g_smp, exp); end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin step(); n++; end
    checks++;
    if (pending()) begin errors++; $display("FAIL drain: tiles still outstanding after %0d cycles", budget); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fifo_push_rdy = 1'b1;
    src_q[0].push_back({1'b1, 32'hDEADBEEF});
    refresh();
    #3;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b expected 0", fifo_push); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (fifo_din !== 32'h0) begin errors++; $display("FAIL reset_din: got %h expected 0", fifo_din); end
    checks++; if (tile_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", tile_count); end
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt: got %b expected 0", preempt); end
    src_q[0].delete();
    do_reset();
  endtask

  task automatic test_single_burst();
    logic [NREQ-1:0] g_tab[5];
    logic            p_tab[5];
    g_tab = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    p_tab = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    add(1, 1'b0); add(1, 1'b0); add(1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (g_smp !== g_tab[c]) begin errors++; $display("FAIL single_grant c%0d: got %b expected %b", c, g_smp, g_tab[c]); end
      checks++; if (push_smp !== p_tab[c]) begin errors++; $display("FAIL single_push c%0d: got %b expected %b", c, push_smp, p_tab[c]); end
    end
    checks++; if (cnt_smp !== 16'd3) begin errors++; $display("FAIL single_count: got %0d expected 3", cnt_smp); end
    checks++; if (preempt_seen != 0) begin errors++; $display("FAIL single_preempt: got %0d pulses expected 0", preempt_seen); end
    // rr_ptr must now be 2: with reqs 1 and 2 both waiting, req 2 wins
    add(1, 1'b1); add(2, 1'b1);
    wait_grant(4'b0100, 6);
    drain(12);
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] g_tab[9];
    g_tab = '{4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
    do_reset();
    add(0, 1'b1); add(0, 1'b1); add(3, 1'b1); add(3, 1'b1);
    for (int c = 0; c < 9; c++) begin
      step();
      checks++; if (g_smp !== g_tab[c]) begin errors++; $display("FAIL rr_grant c%0d: got %b expected %b", c, g_smp, g_tab[c]); end
    end
    checks++; if (cnt_smp !== 16'd4) begin errors++; $display("FAIL rr_count: got %0d expected 4", cnt_smp); end
    drain(2);
  endtask

  task automatic test_backpressure();
    do_reset();
    fifo_push_rdy = 1'b0;
    add(2, 1'b1);
    step();
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++; if (g_smp !== 4'b0100) begin errors++; $display("FAIL bp_grant c%0d: got %b expected 0100", c, g_smp); end
      checks++; if (push_smp !== 1'b0) begin errors++; $display("FAIL bp_push c%0d: got %b expected 0", c, push_smp); end
      checks++; if (rdy_smp !== 4'b0000) begin errors++; $display("FAIL bp_ready c%0d: got %b expected 0000", c, rdy_smp); end
      checks++; if (cnt_smp !== 16'd0) begin errors++; $display("FAIL bp_count c%0d: got %0d expected 0", c, cnt_smp); end
    end
    fifo_push_rdy = 1'b1;
    step();
    checks++; if (push_smp !== 1'b1) begin errors++; $display("FAIL bp_release_push: got %b expected 1", push_smp); end
    checks++; if (rdy_smp !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b expected 0100", rdy_smp); end
    step();
    checks++; if (g_smp !== 4'b0000) begin errors++; $display("FAIL bp_after_grant: got %b expected 0000", g_smp); end
    checks++; if (cnt_smp !== 16'd1) begin errors++; $display("FAIL bp_after_count: got %0d expected 1", cnt_smp); end
    drain(2);
  endtask

  task automatic test_preempt();
    logic [NREQ-1:0] g_tab[11];
    logic            p_tab[11];
    g_tab = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
              4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    p_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int k = 0; k < 6; k++) add(0, (k == 5));
    add(1, 1'b1);
    for (int c = 0; c < 11; c++) begin
      step();
      checks++; if (g_smp !== g_tab[c]) begin errors++; $display("FAIL pre_grant c%0d: got %b expected %b", c, g_smp, g_tab[c]); end
      checks++; if (pre_smp !== p_tab[c]) begin errors++; $display("FAIL pre_pulse c%0d: got %b expected %b", c, pre_smp, p_tab[c]); end
    end
    checks++; if (cnt_smp !== 16'd7) begin errors++; $display("FAIL pre_count: got %0d expected 7", cnt_smp); end
    checks++; if (preempt_seen != 1) begin errors++; $display("FAIL pre_pulses: got %0d expected 1", preempt_seen); end
    drain(2);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int k = 0; k < 4; k++) add(0, (k == 3));
    add(2, 1'b1);
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_grant: got %b expected 0000", grant); end
    checks++; if (fifo_push !== 1'b0) begin errors++; $display("FAIL mid_push: got %b expected 0", fifo_push); end
    checks++; if (tile_count !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", tile_count); end
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL mid_preempt: got %b expected 0", preempt); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready: got %b expected 0000", req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_grant(4'b0001, 4);
    drain(20);
    step();
    checks++; if (cnt_smp !== 16'd3) begin errors++; $display("FAIL mid_final_count: got %0d expected 3", cnt_smp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_preempt();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tile_push_arbiter.md
Name: tile_push_arbiter

Overview:
- Shares the push port of one tile FIFO among NREQ tile producers, such as DMA channels or activation and weight loaders.
- Arbitration is round-robin, with a burst grant: a winner holds the FIFO until it delivers a tile marked last, or until MAX_BURST tiles have been accepted.
- Sits between the producers and the tile FIFO's push/push_rdy/din interface, and muxes the selected producer's tile onto din.

Parameters:
- BITS, 8, bits per tile element.
- SIZE, 2, tile dimension; a tile is SIZE x SIZE elements.
- NREQ, 4, number of requesters; must be at least 2.
- MAX_BURST, 4, maximum tiles accepted per grant before forced release; must be at least 1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  [NREQ]  requester i has a tile available.
- req_last  input  [NREQ]  requester i's current tile ends its burst.
- req_data  input  [NREQ][SIZE][SIZE] x BITS  requester tiles.
- req_ready  output  [NREQ]  tile from requester i is accepted this cycle when also valid.
- fifo_push  output  1  push strobe to the tile FIFO.
- fifo_push_rdy  input  1  tile FIFO not full.
- fifo_din  output  [SIZE][SIZE] x BITS  tile to the FIFO.
- grant  output  [NREQ]  one-hot registered grant; all zero when idle.
- preempt  output  1  one-cycle pulse: the previous grant was force-released at MAX_BURST.
- tile_count  output  16  total tiles pushed, wraps modulo 2^16.

Behaviour:
- Reset: asynchronous; rst_n low forces the following immediately, regardless of state, including mid-burst.
  - state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, preempt=0, tile_count=0.
  - req_ready=0, fifo_push=0, fifo_din=0.
- Any burst in progress at reset is abandoned; no partial-burst state survives.
- Handshake: a beat from requester g is accepted in a cycle iff grant[g] & req_valid[g] & fifo_push_rdy.
- States: IDLE and GRANT.
- IDLE:
  - req_ready=0, fifo_push=0, fifo_din=0.
  - If any req_valid is set, select the first set index searching upward from rr_ptr, wrapping NREQ-1 -> 0.
  - Next cycle: grant[g]=1, state=GRANT, beat_cnt=0.
  - Otherwise remain in IDLE.
  - Arbitration costs one cycle; there is always one bubble cycle between grants.
- GRANT (index g), all combinational from the registered grant:
  - req_ready[g]=fifo_push_rdy; all other req_ready=0.
  - fifo_din=req_data[g].
  - fifo_push=req_valid[g] & fifo_push_rdy.
  - fifo_push is never asserted while fifo_push_rdy=0, so the FIFO never sees a push while full.
- On each accepted beat, tile_count increments by 1.
- Release: the grant releases on an accepted beat when req_last[g]=1 or beat_cnt==MAX_BURST-1.
  - Next cycle: state=IDLE, grant=0, rr_ptr=(g+1) mod NREQ.
  - If the release is due to the beat count with req_last[g]=0, preempt=1 for exactly that next cycle.
  - If req_last and the beat count coincide, this is a normal release and preempt=0.
- Accepted beat without release: beat_cnt increments and the grant is held.
- Requester drops req_valid while granted: the grant is held indefinitely and no beats transfer. No timeout.
- FIFO stalls (fifo_push_rdy=0): the grant is held and beat_cnt does not advance.
- A preempted requester later resumes its burst under a fresh grant, with beat_cnt=0. Its data is unaffected.
- MAX_BURST=1: every accepted beat releases the grant. preempt pulses when req_last=0 on that beat.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr is $clog2(NREQ) bits, with explicit wrap at NREQ, so NREQ need not be a power of 2.
- req_data must be stable while req_valid is high and not yet accepted. fifo_din passes it through with zero latency.

Test Plan:
- Single requester 3-beat burst: req 1 valid with tiles A, B, C(last); fifo_push_rdy=1.
  - grant=0010 from cycle 1.
  - Pushes A, B, C in cycles 1-3.
  - grant=0 in cycle 4; rr_ptr=2; tile_count=3; preempt never asserted.
- Round-robin with simultaneous requests: reqs 0 and 3 both have 1-tile bursts (last=1), held valid, starting from reset.
  - Grant order 0, 3, 0, 3, each separated by one idle cycle.
  - This confirms rr_ptr wraps 3 -> 0 -> 1.
- FIFO backpressure: grant on req 2 with fifo_push_rdy=0 for 5 cycles, then 1.
  - fifo_push=0 and req_ready=0 for those 5 cycles.
  - Tile pushed on the first ready cycle; beat_cnt and tile_count unchanged during the stall.
- Preemption: req 0 offers 6 tiles, last only on the 6th, with MAX_BURST=4.
  - 4 tiles pushed, then preempt=1 for one cycle and grant=0.
  - The next grant, if req 1 is waiting, goes to req 1.
  - Req 0 later completes 2 tiles with preempt=0.
- Reset mid-burst: assert rst_n low after the 2nd tile of a 4-tile burst.
  - grant, fifo_push, tile_count and preempt all read 0 immediately, without waiting for a clock edge.
  - After release, the lowest valid index at or above 0 wins.
